// File: rtl/fetch_word_addr_unit.sv
// ---------------------------------------------------------------------------
// fetch_word_addr_unit
//
// Purpose:
//   Instruction-fetch front end for a single-issue MIPS datapath. Holds the
//   byte-addressed program counter and computes the sequential, branch and
//   jump targets. The byte PC is turned into a word index that drives
//   instruction memory through a ready handshake. Accepted fetches are
//   reported to IF/ID as a registered FetchValid/FetchPC pair.
//
// Parameters:
//   RESET_PC  byte address loaded into PC on reset (word aligned)
//   ADDR_W    width of the instruction-memory word index
//
// Ports:
//   Clk, Rst_n     clock, asynchronous active-low reset
//   Stall          freezes PC/FSM/FetchPC and masks acceptance
//   BranchTaken    branch redirect, target PC+4 + (BranchOffset << 2)
//   BranchOffset   sign-extended word offset
//   JumpEn         J-type redirect, target {PCPlus4[31:28], JumpIndex, 2'b00}
//   JumpIndex      J-type instruction index
//   JumpRegEn      JR redirect, target JumpRegTarget
//   JumpRegTarget  byte target of JR
//   IMemReady      memory accepts the current request
//   IMemReq        fetch request (high in REQ)
//   IMemWordAddr   PC[ADDR_W+1:2]
//   PC, PCPlus4    current byte PC and PC + 4
//   FetchValid     one-cycle pulse: a fetch was accepted last cycle
//   FetchPC        byte PC of the fetch flagged by FetchValid
//   MisalignErr    sticky: a redirect target was not word aligned
//   FetchCount     (only with FETCH_PERF_COUNT_EN) non-squashed acceptances
//
// Configuration:
//   Define FETCH_PERF_COUNT_EN to add the FetchCount output and counter.
// ---------------------------------------------------------------------------
module fetch_word_addr_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [31:0]       BranchOffset,
  input  logic              JumpEn,
  input  logic [25:0]       JumpIndex,
  input  logic              JumpRegEn,
  input  logic [31:0]       JumpRegTarget,
  input  logic              IMemReady,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemWordAddr,
  output logic [31:0]       PC,
  output logic [31:0]       PCPlus4,
  output logic              FetchValid,
  output logic [31:0]       FetchPC,
`ifdef FETCH_PERF_COUNT_EN
  output logic [31:0]       FetchCount,
`endif
  output logic              MisalignErr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_fetch_valid;
  logic [31:0] r_fetch_pc;
  logic        r_misalign;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_redir_target;
  logic        w_redir_req;
  logic        w_redirect;
  logic        w_misalign;
  logic        w_accept;
  logic        w_fetch_valid_next;

  // Arithmetic is modulo 2^32; wraparound is intentionally silent.
  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_target = w_pc_plus4 + (BranchOffset << 2);
  assign w_jump_target   = {w_pc_plus4[31:28], JumpIndex, 2'b00};

  // JR outranks J, which outranks a taken branch.
  always_comb begin
    w_redir_target = w_branch_target;
    if (JumpRegEn) begin
      w_redir_target = JumpRegTarget;
    end else if (JumpEn) begin
      w_redir_target = w_jump_target;
    end
  end

  assign w_redir_req = JumpRegEn | JumpEn | BranchTaken;
  // Redirects are ignored while stalled and once halted.
  assign w_redirect  = w_redir_req && !Stall && (r_state != S_HALT);
  // Only JR can actually misalign; the check is on the selected target anyway.
  assign w_misalign  = w_redirect && (w_redir_target[1:0] != 2'b00);
  assign w_accept    = (r_state == S_REQ) && IMemReady && !Stall;
  // A redirect in the same cycle squashes the accepted fetch.
  assign w_fetch_valid_next = w_accept && !w_redirect;

  // Next-state / next-PC logic.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (!Stall) begin
      case (r_state)
        S_IDLE:  w_state_next = S_REQ;
        S_REQ:   w_state_next = S_REQ;
        default: w_state_next = S_HALT;
      endcase
      if (w_misalign) begin
        w_state_next = S_HALT;
      end
      if (w_redirect) begin
        // A misaligned target is still loaded so the fault PC is visible.
        w_pc_next = w_redir_target;
      end else if (w_accept) begin
        w_pc_next = w_pc_plus4;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_fetch_pc    <= 32'd0;
      r_misalign    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_fetch_valid <= w_fetch_valid_next;
      if (w_fetch_valid_next) begin
        r_fetch_pc <= r_pc;
      end
      if (w_misalign) begin
        r_misalign <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_fetch_count <= 32'd0;
    end else if (w_fetch_valid_next) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign FetchCount = r_fetch_count;
`endif

  // The request is a pure function of state, so a stall (which freezes
  // state) automatically keeps IMemReq at its current value.
  assign IMemReq      = (r_state == S_REQ);
  assign IMemWordAddr = r_pc[ADDR_W+1:2];
  assign PC           = r_pc;
  assign PCPlus4      = w_pc_plus4;
  assign FetchValid   = r_fetch_valid;
  assign FetchPC      = r_fetch_pc;
  assign MisalignErr  = r_misalign;

endmodule

// File: tb/tb_fetch_word_addr_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_word_addr_unit
//
// Directed bench for fetch_word_addr_unit with RESET_PC=0, ADDR_W=10.
// Inputs change 1 time unit after the rising edge; outputs are checked at
// that same point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_word_addr_unit;

  localparam int ADDR_W = 10;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              Stall;
  logic              BranchTaken;
  logic [31:0]       BranchOffset;
  logic              JumpEn;
  logic [25:0]       JumpIndex;
  logic              JumpRegEn;
  logic [31:0]       JumpRegTarget;
  logic              IMemReady;
  logic              IMemReq;
  logic [ADDR_W-1:0] IMemWordAddr;
  logic [31:0]       PC;
  logic [31:0]       PCPlus4;
  logic              FetchValid;
  logic [31:0]       FetchPC;
  logic              MisalignErr;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0]       FetchCount;
  int                pulse_cnt = 0;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;

  fetch_word_addr_unit #(
    .RESET_PC(32'h0000_0000),
    .ADDR_W  (ADDR_W)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchOffset (BranchOffset),
    .JumpEn       (JumpEn),
    .JumpIndex    (JumpIndex),
    .JumpRegEn    (JumpRegEn),
    .JumpRegTarget(JumpRegTarget),
    .IMemReady    (IMemReady),
    .IMemReq      (IMemReq),
    .IMemWordAddr (IMemWordAddr),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .FetchValid   (FetchValid),
    .FetchPC      (FetchPC),
`ifdef FETCH_PERF_COUNT_EN
    .FetchCount   (FetchCount),
`endif
    .MisalignErr  (MisalignErr)
  );

  always #5 Clk = ~Clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
`ifdef FETCH_PERF_COUNT_EN
    if (!Rst_n) pulse_cnt = 0;
    else if (FetchValid === 1'b1) pulse_cnt++;
`endif
  endtask

  task automatic clear_inputs();
    Stall = 0; BranchTaken = 0; BranchOffset = 0; JumpEn = 0; JumpIndex = 0;
    JumpRegEn = 0; JumpRegTarget = 0; IMemReady = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Rst_n = 0;
    tick(); tick();
    check_cnt++; if (PC !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); else pass_cnt++;
    check_cnt++; if (IMemReq !== 1'b0) $display("FAIL reset_req got=%b exp=0", IMemReq); else pass_cnt++;
    check_cnt++; if (FetchValid !== 1'b0 || FetchPC !== 32'h0 || MisalignErr !== 1'b0)
      $display("FAIL reset_outs got fv=%b fpc=%h me=%b exp 0/0/0", FetchValid, FetchPC, MisalignErr); else pass_cnt++;
    Rst_n = 1; IMemReady = 1;
    // Released but not yet clocked: still IDLE.
    check_cnt++; if (IMemReq !== 1'b0) $display("FAIL idle_req got=%b exp=0", IMemReq); else pass_cnt++;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_cnt++;
      if (IMemWordAddr !== ADDR_W'(i) || IMemReq !== 1'b1)
        $display("FAIL seq_addr[%0d] got=%0d req=%b exp=%0d req=1", i, IMemWordAddr, IMemReq, i);
      else pass_cnt++;
      check_cnt++;
      if (i == 0) begin
        if (FetchValid !== 1'b0) $display("FAIL seq_fv[0] got=%b exp=0", FetchValid); else pass_cnt++;
      end else begin
        if (FetchValid !== 1'b1 || FetchPC !== 32'((i - 1) * 4))
          $display("FAIL seq_fpc[%0d] got fv=%b fpc=%h exp fv=1 fpc=%h", i, FetchValid, FetchPC, 32'((i - 1) * 4));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_branch();
    // PC is 0x10 here.
    IMemReady = 0; BranchTaken = 1; BranchOffset = 32'hFFFF_FFFE;
    tick();
    BranchTaken = 0;
    check_cnt++; if (PC !== 32'h0000_000C || IMemWordAddr !== 10'd3 || FetchValid !== 1'b0)
      $display("FAIL branch got pc=%h wa=%0d fv=%b exp pc=0000000c wa=3 fv=0", PC, IMemWordAddr, FetchValid); else pass_cnt++;
  endtask

  task automatic test_jump();
    JumpRegEn = 1; JumpRegTarget = 32'h4000_0010;
    tick();
    JumpRegEn = 0;
    check_cnt++; if (PC !== 32'h4000_0010) $display("FAIL jr_setup got=%h exp=40000010", PC); else pass_cnt++;
    JumpEn = 1; JumpIndex = 26'h0000040; BranchTaken = 1; BranchOffset = 32'h0000_0100;
    tick();
    JumpEn = 0; BranchTaken = 0;
    check_cnt++; if (PC !== 32'h4000_0100) $display("FAIL jump_prio got=%h exp=40000100", PC); else pass_cnt++;
  endtask

  task automatic test_stall_handshake();
    // IMemReady still 0; PC = 0x4000_0100, FetchPC last = 0xC.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cnt++; if (PC !== 32'h4000_0100 || FetchValid !== 1'b0 || IMemReq !== 1'b1)
        $display("FAIL notready[%0d] got pc=%h fv=%b req=%b exp pc=40000100 fv=0 req=1", i, PC, FetchValid, IMemReq); else pass_cnt++;
    end
    IMemReady = 1; Stall = 1; JumpRegEn = 1; JumpRegTarget = 32'h0000_0800;
    tick();
    JumpRegEn = 0;
    check_cnt++; if (PC !== 32'h4000_0100 || FetchValid !== 1'b0 || FetchPC !== 32'h0000_000C || IMemReq !== 1'b1)
      $display("FAIL stall got pc=%h fv=%b fpc=%h req=%b exp pc=40000100 fv=0 fpc=0000000c req=1", PC, FetchValid, FetchPC, IMemReq); else pass_cnt++;
    Stall = 0;
    tick();
    IMemReady = 0;
    check_cnt++; if (PC !== 32'h4000_0104 || FetchValid !== 1'b1 || FetchPC !== 32'h4000_0100)
      $display("FAIL unstall got pc=%h fv=%b fpc=%h exp pc=40000104 fv=1 fpc=40000100", PC, FetchValid, FetchPC); else pass_cnt++;
    tick();
    check_cnt++; if (FetchValid !== 1'b0 || PC !== 32'h4000_0104)
      $display("FAIL single_pulse got fv=%b pc=%h exp fv=0 pc=40000104", FetchValid, PC); else pass_cnt++;
  endtask

  task automatic test_squash();
    JumpRegEn = 1; JumpRegTarget = 32'h0000_0020;
    tick();
    JumpRegEn = 0;
    IMemReady = 1; BranchTaken = 1; BranchOffset = 32'h0000_0004;
    tick();
    BranchTaken = 0; IMemReady = 0;
    check_cnt++; if (FetchValid !== 1'b0 || PC !== 32'h0000_0034 || FetchPC !== 32'h4000_0100)
      $display("FAIL squash got fv=%b pc=%h fpc=%h exp fv=0 pc=00000034 fpc=40000100", FetchValid, PC, FetchPC); else pass_cnt++;
  endtask

  task automatic test_misalign_reset();
    IMemReady = 1; JumpRegEn = 1; JumpRegTarget = 32'h0000_0102;
    tick();
    check_cnt++; if (MisalignErr !== 1'b1 || IMemReq !== 1'b0 || PC !== 32'h0000_0102 || FetchValid !== 1'b0)
      $display("FAIL misalign got me=%b req=%b pc=%h fv=%b exp me=1 req=0 pc=00000102 fv=0", MisalignErr, IMemReq, PC, FetchValid); else pass_cnt++;
    // Later redirects must be ignored while halted.
    JumpRegTarget = 32'h0000_0200;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_cnt++; if (MisalignErr !== 1'b1 || IMemReq !== 1'b0 || PC !== 32'h0000_0102 || FetchValid !== 1'b0)
        $display("FAIL halt[%0d] got me=%b req=%b pc=%h fv=%b exp me=1 req=0 pc=00000102 fv=0", i, MisalignErr, IMemReq, PC, FetchValid); else pass_cnt++;
    end
    JumpRegEn = 0;
`ifdef FETCH_PERF_COUNT_EN
    check_cnt++; if (FetchCount !== 32'(pulse_cnt))
      $display("FAIL perf_count got=%0d exp=%0d", FetchCount, pulse_cnt); else pass_cnt++;
`endif
    #2;
    Rst_n = 0;
    #1;
    check_cnt++; if (PC !== 32'h0 || IMemReq !== 1'b0 || MisalignErr !== 1'b0 || FetchValid !== 1'b0 || FetchPC !== 32'h0)
      $display("FAIL async_reset got pc=%h req=%b me=%b fv=%b fpc=%h exp all 0", PC, IMemReq, MisalignErr, FetchValid, FetchPC); else pass_cnt++;
`ifdef FETCH_PERF_COUNT_EN
    check_cnt++; if (FetchCount !== 32'd0) $display("FAIL perf_reset got=%0d exp=0", FetchCount); else pass_cnt++;
`endif
    tick();
    Rst_n = 1;
    tick();
    check_cnt++; if (IMemReq !== 1'b1 || IMemWordAddr !== 10'd0)
      $display("FAIL resume_req got req=%b wa=%0d exp req=1 wa=0", IMemReq, IMemWordAddr); else pass_cnt++;
    tick();
    check_cnt++; if (FetchValid !== 1'b1 || FetchPC !== 32'h0 || PC !== 32'h4)
      $display("FAIL resume_fetch got fv=%b fpc=%h pc=%h exp fv=1 fpc=0 pc=4", FetchValid, FetchPC, PC); else pass_cnt++;
`ifdef FETCH_PERF_COUNT_EN
    check_cnt++; if (FetchCount !== 32'd1) $display("FAIL perf_resume got=%0d exp=1", FetchCount); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall_handshake();
    test_squash();
    test_misalign_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
